// File: rtl/npu_pkg.sv
// Shared NPU constants and types for the block scheduler and its tile walker.
package npu_pkg;

    localparam int IDX_W  = 10;
    localparam int J      = 2;
    localparam int K      = 2;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT
    } sched_state_t;

endpackage

// File: rtl/block_scheduler_tile_walker.sv
// Tile-origin counters: walks J x K block origins in row-major order over a rows x cols matrix.
module tile_walker #(
    parameter int J     = npu_pkg::J,
    parameter int K     = npu_pkg::K,
    parameter int IDX_W = npu_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             advance,
    input  logic [IDX_W-1:0] rows,
    input  logic [IDX_W-1:0] cols,
    output logic [IDX_W-1:0] start_row,
    output logic [IDX_W-1:0] start_col,
    output logic [IDX_W-1:0] blk_idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] J_STEP = IDX_W'(J);
    localparam logic [IDX_W-1:0] K_STEP = IDX_W'(K);

    logic col_end;
    logic row_end;

    assign col_end = (start_col + K_STEP) == cols;
    assign row_end = (start_row + J_STEP) == rows;
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            start_row <= '0;
            start_col <= '0;
            blk_idx   <= '0;
        end else if (advance) begin
            blk_idx <= blk_idx + IDX_W'(1);
            if (col_end) begin
                start_col <= '0;
                start_row <= start_row + J_STEP;
            end else begin
                start_col <= start_col + K_STEP;
            end
        end
    end

endmodule

// File: rtl/block_scheduler.sv
// Sequences get_block tile fetches: validates the matrix shape, issues block origins,
// waits out the fetch latency and hands each block to the consumer via valid/ready.
module block_scheduler
    import npu_pkg::*;
#(
    parameter int J         = npu_pkg::J,
    parameter int K         = npu_pkg::K,
    parameter int IDX_W     = npu_pkg::IDX_W,
    parameter int BUF_DEPTH = 16,
    parameter int FETCH_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] mat_rows,
    input  logic [IDX_W-1:0] mat_cols,
    output logic [IDX_W-1:0] start_row,
    output logic [IDX_W-1:0] start_col,
    output logic [IDX_W-1:0] num_cols,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_last,
    output logic [IDX_W-1:0] blk_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int LAT_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam logic [LAT_W-1:0]     LAT_LOAD = LAT_W'(FETCH_LAT - 1);
    localparam logic [IDX_W-1:0]     J_STEP   = IDX_W'(J);
    localparam logic [IDX_W-1:0]     K_STEP   = IDX_W'(K);
    localparam logic [2*IDX_W-1:0]   BUF_LIM  = (2*IDX_W)'(BUF_DEPTH);

    sched_state_t     state;
    logic [LAT_W-1:0] lat_cnt;
    logic [IDX_W-1:0] rows_q;
    logic [IDX_W-1:0] cols_q;
    logic             cfg_ok;
    logic             init;
    logic             advance;
    logic             last;
    logic             take;

    // Product is formed at double width so a large shape cannot wrap past the buffer check.
    function automatic logic config_ok(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
        logic [2*IDX_W-1:0] prod;
        prod = {{IDX_W{1'b0}}, r} * {{IDX_W{1'b0}}, c};
        return (r != '0) && (c != '0) &&
               ((r % J_STEP) == '0) && ((c % K_STEP) == '0) &&
               (prod <= BUF_LIM);
    endfunction

    assign cfg_ok  = config_ok(mat_rows, mat_cols);
    assign init    = (state == IDLE) && start && cfg_ok;
    assign take    = (state == PRESENT) && blk_ready && !abort;
    assign advance = take && !last;

    assign num_cols = cols_q;
    assign busy     = (state != IDLE);
    assign blk_last = blk_valid && last;

    tile_walker #(
        .J     (J),
        .K     (K),
        .IDX_W (IDX_W)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .advance   (advance),
        .rows      (rows_q),
        .cols      (cols_q),
        .start_row (start_row),
        .start_col (start_col),
        .blk_idx   (blk_idx),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            blk_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q <= mat_rows;
                        cols_q <= mat_cols;
                        if (cfg_ok) begin
                            state <= ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (lat_cnt == '0) begin
                        blk_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                PRESENT: begin
                    // abort beats a simultaneous ready: the block is treated as not consumed
                    if (abort) begin
                        blk_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (blk_ready) begin
                        blk_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: begin
                    blk_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: table of shapes plus hand-written corner sequences.
module tb_block_scheduler;

    localparam int IDX_W     = 10;
    localparam int J         = 2;
    localparam int K         = 2;
    localparam int BUF_DEPTH = 16;
    localparam int FETCH_LAT = 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] mat_rows;
    logic [IDX_W-1:0] mat_cols;
    logic [IDX_W-1:0] start_row;
    logic [IDX_W-1:0] start_col;
    logic [IDX_W-1:0] num_cols;
    logic             blk_valid;
    logic             blk_ready;
    logic             blk_last;
    logic [IDX_W-1:0] blk_idx;
    logic             busy;
    logic             done;
    logic             err;

    block_scheduler #(
        .J         (J),
        .K         (K),
        .IDX_W     (IDX_W),
        .BUF_DEPTH (BUF_DEPTH),
        .FETCH_LAT (FETCH_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mat_rows  (mat_rows),
        .mat_cols  (mat_cols),
        .start_row (start_row),
        .start_col (start_col),
        .num_cols  (num_cols),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last),
        .blk_idx   (blk_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int row;
        int col;
        int idx;
        int last;
    } tile_t;

    typedef struct {
        int rows;
        int cols;
        int exp_err;
        int exp_tiles;
    } vec_t;

    tile_t sb[$];
    vec_t  vecs[13];

    int compared;
    int mismatched;
    int cycle;
    int done_cnt;
    int hs_cnt;
    int prev_ev;
    int exp_gap;
    bit chk_gap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_scan(input int rows, input int cols);
        tile_t t;
        int    n;
        n = 0;
        for (int r = 0; r < rows; r += J) begin
            for (int c = 0; c < cols; c += K) begin
                t.row  = r;
                t.col  = c;
                t.idx  = n;
                t.last = ((r + J == rows) && (c + K == cols)) ? 1 : 0;
                sb.push_back(t);
                n++;
            end
        end
    endtask

    // Handshakes are judged on the values seen just before the edge that accepts them.
    task automatic cyc();
        tile_t e;
        bit    was_last;
        was_last = 1'b0;
        chk("last_without_valid", int'(blk_last & ~blk_valid), 0);
        if (blk_valid && blk_ready && !abort && !rst) begin
            hs_cnt++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL tile_unexpected: got (%0d,%0d) idx %0d, required no handshake",
                         start_row, start_col, blk_idx);
            end else begin
                e = sb.pop_front();
                was_last = (e.last != 0);
                if (int'(start_row) != e.row || int'(start_col) != e.col ||
                    int'(blk_idx) != e.idx || int'(blk_last) != e.last) begin
                    mismatched++;
                    $display("FAIL tile: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                             start_row, start_col, blk_idx, blk_last, e.row, e.col, e.idx, e.last);
                end
            end
            if (chk_gap) begin
                chk("handshake_spacing", cycle - prev_ev, exp_gap);
                prev_ev = cycle;
                exp_gap = FETCH_LAT + 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        if (was_last) chk("done_after_last", int'(done), 1);
        else if (done) chk("done_unexpected", int'(done), 0);
        if (done) done_cnt++;
    endtask

    task automatic pulse_start(input int rows, input int cols);
        mat_rows = IDX_W'(rows);
        mat_cols = IDX_W'(cols);
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!blk_valid && n < budget) begin
            cyc();
            n++;
        end
        chk("valid_within_budget", int'(blk_valid), 1);
    endtask

    task automatic run_to_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
        chk("done_within_budget", done_cnt - d0, 1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            cyc();
            n++;
        end
        chk("handshakes_reached", hs_cnt, target);
    endtask

    initial begin
        int r0;
        int c0;
        int h0;
        int d0;

        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        done_cnt   = 0;
        hs_cnt     = 0;
        prev_ev    = 0;
        exp_gap    = 0;
        chk_gap    = 1'b0;

        vecs[0]  = '{4, 4, 0, 4};
        vecs[1]  = '{3, 4, 1, 0};
        vecs[2]  = '{0, 4, 1, 0};
        vecs[3]  = '{4, 8, 1, 0};
        vecs[4]  = '{2, 2, 0, 1};
        vecs[5]  = '{2, 4, 0, 2};
        vecs[6]  = '{4, 2, 0, 2};
        vecs[7]  = '{4, 0, 1, 0};
        vecs[8]  = '{4, 3, 1, 0};
        vecs[9]  = '{2, 8, 0, 4};
        vecs[10] = '{8, 2, 0, 4};
        vecs[11] = '{2, 6, 0, 3};
        vecs[12] = '{4, 6, 1, 0};

        rst       = 1'b1;
        start     = 1'b1;
        abort     = 1'b1;
        mat_rows  = 10'd4;
        mat_cols  = 10'd4;
        blk_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("reset_start_row", int'(start_row), 0);
        chk("reset_start_col", int'(start_col), 0);
        chk("reset_num_cols", int'(num_cols), 0);
        chk("reset_blk_idx", int'(blk_idx), 0);
        chk("reset_blk_valid", int'(blk_valid), 0);
        chk("reset_blk_last", int'(blk_last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cyc();

        chk_gap   = 1'b1;
        blk_ready = 1'b1;
        foreach (vecs[i]) begin
            r0 = int'(start_row);
            c0 = int'(start_col);
            if (vecs[i].exp_err == 0) push_scan(vecs[i].rows, vecs[i].cols);
            pulse_start(vecs[i].rows, vecs[i].cols);
            chk($sformatf("err_%0dx%0d", vecs[i].rows, vecs[i].cols), int'(err), vecs[i].exp_err);
            chk($sformatf("busy_%0dx%0d", vecs[i].rows, vecs[i].cols), int'(busy), 1 - vecs[i].exp_err);
            if (vecs[i].exp_err != 0) begin
                cyc();
                chk("err_one_cycle", int'(err), 0);
                chk("reject_busy_low", int'(busy), 0);
                chk("reject_row_kept", int'(start_row), r0);
                chk("reject_col_kept", int'(start_col), c0);
            end else begin
                prev_ev = cycle;
                exp_gap = FETCH_LAT + 1;
                h0      = hs_cnt;
                run_to_done(200);
                chk($sformatf("tiles_%0dx%0d", vecs[i].rows, vecs[i].cols), hs_cnt - h0, vecs[i].exp_tiles);
                chk("idle_after_done", int'(busy), 0);
            end
        end
        chk_gap = 1'b0;

        // Backpressure: tile 1 held for five cycles with ready low
        push_scan(4, 4);
        blk_ready = 1'b0;
        pulse_start(4, 4);
        wait_valid(10);
        blk_ready = 1'b1;
        cyc();
        blk_ready = 1'b0;
        wait_valid(10);
        for (int n = 0; n < 5; n++) begin
            chk("hold_valid", int'(blk_valid), 1);
            chk("hold_row", int'(start_row), 0);
            chk("hold_col", int'(start_col), 2);
            chk("hold_idx", int'(blk_idx), 1);
            cyc();
        end
        blk_ready = 1'b1;
        run_to_done(100);

        // Abort in WAIT during tile 2, then a fresh 2x2 scan
        push_scan(4, 4);
        h0 = hs_cnt;
        pulse_start(4, 4);
        wait_hs(h0 + 2, 50);
        cyc();
        chk("abort_pre_wait_valid", int'(blk_valid), 0);
        chk("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_valid_low", int'(blk_valid), 0);
        d0 = done_cnt;
        cyc();
        cyc();
        chk("abort_no_done", done_cnt - d0, 0);
        sb.delete();
        push_scan(2, 2);
        pulse_start(2, 2);
        wait_valid(10);
        chk("single_tile_last", int'(blk_last), 1);
        run_to_done(20);

        // start during PRESENT with new dimensions is ignored
        push_scan(4, 4);
        blk_ready = 1'b0;
        pulse_start(4, 4);
        wait_valid(10);
        pulse_start(2, 2);
        chk("busy_start_no_err", int'(err), 0);
        chk("busy_start_valid_kept", int'(blk_valid), 1);
        chk("busy_start_idx_kept", int'(blk_idx), 0);
        chk("busy_start_num_cols", int'(num_cols), 4);
        blk_ready = 1'b1;
        run_to_done(100);
        chk("num_cols_original", int'(num_cols), 4);

        // Reset mid-scan in PRESENT together with ready
        push_scan(4, 4);
        h0 = hs_cnt;
        pulse_start(4, 4);
        wait_hs(h0 + 1, 20);
        blk_ready = 1'b0;
        wait_valid(10);
        chk("pre_rst_col", int'(start_col), 2);
        rst       = 1'b1;
        blk_ready = 1'b1;
        cyc();
        chk("rst_start_row", int'(start_row), 0);
        chk("rst_start_col", int'(start_col), 0);
        chk("rst_num_cols", int'(num_cols), 0);
        chk("rst_blk_idx", int'(blk_idx), 0);
        chk("rst_blk_valid", int'(blk_valid), 0);
        chk("rst_blk_last", int'(blk_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst       = 1'b0;
        blk_ready = 1'b0;
        sb.delete();
        d0 = done_cnt;
        cyc();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_stays_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/block_scheduler.md
Name: block_scheduler

Overview:
- Sequences the `get_block` tile-extraction datapath over a row-major matrix held in the shared buffer.
- Walks J×K block origins in row-major tile order and drives `start_row`, `start_col` and `num_cols` into the fetch unit.
- Waits out the fetch latency, then presents each block to the downstream consumer with a valid/ready handshake.
- Sits between the top-level command interface and the compute array; it carries no block data itself.

Parameters:
- J, `J, block rows.
- K, `K, block columns.
- IDX_W, 10, coordinate and dimension width.
- BUF_DEPTH, 16, element capacity of the shared buffer.
- FETCH_LAT, 1, cycles from a coordinate change to a valid block at the `get_block` output (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a scan. Ignored unless in IDLE.
- abort  in  1  abandons the current scan.
- mat_rows  in  IDX_W  matrix row count; sampled on start.
- mat_cols  in  IDX_W  matrix column count; sampled on start.
- start_row  out  IDX_W  to `get_block`: block origin row.
- start_col  out  IDX_W  to `get_block`: block origin column.
- num_cols  out  IDX_W  to `get_block`: latched mat_cols.
- blk_valid  out  1  block at the `get_block` output is valid.
- blk_ready  in  1  consumer accepts the block.
- blk_last  out  1  qualifies blk_valid; marks the final tile.
- blk_idx  out  IDX_W  tile ordinal, 0-based.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last handshake.
- err  out  1  one-cycle pulse on configuration reject.

Behaviour:
- Reset (clk edge with rst=1): state IDLE. start_row, start_col, num_cols, blk_idx, lat_cnt all 0. blk_valid, blk_last, busy, done, err all 0. rst overrides start and abort.
- States: IDLE, ISSUE, WAIT, PRESENT.
- IDLE, on start: latch mat_rows and mat_cols.
  - Reject if any of: rows=0, cols=0, rows%J≠0, cols%K≠0, or rows*cols>BUF_DEPTH. Compute the product at 2*IDX_W width. On reject: err=1 for one cycle, stay IDLE.
  - Otherwise: start_row=0, start_col=0, blk_idx=0, go to ISSUE.
- ISSUE: coordinates are stable. Load lat_cnt=FETCH_LAT-1, go to WAIT.
- WAIT: decrement lat_cnt. At 0, go to PRESENT with blk_valid=1 registered, so blk_valid rises exactly FETCH_LAT+1 cycles after coordinates change.
- PRESENT: hold blk_valid, coordinates, blk_idx and blk_last stable until blk_ready=1.
  - On handshake, if not last: advance start_col+=K. If start_col+K==cols, set start_col=0 and start_row+=J. blk_idx+=1. blk_valid=0. Go to ISSUE.
  - On handshake of the last tile (start_row+J==rows and start_col+K==cols): blk_valid=0, done=1 for one cycle, go to IDLE. Coordinates keep their final values.
- blk_last = blk_valid & last-tile condition. It is never high without blk_valid.
- Throughput: one block per FETCH_LAT+2 cycles when blk_ready is held high.
- abort, in any non-IDLE state: next cycle IDLE, blk_valid=0, no done pulse. abort in IDLE has no effect. If abort and blk_ready coincide in PRESENT, abort wins and the block counts as not consumed.
- start while busy: ignored, no err.
- blk_ready outside PRESENT: ignored.
- Coordinate arithmetic is IDX_W wide. Overflow cannot occur after the config check passes.

Decomposition:
- Shared package `npu_pkg`:
  - sched_state_t enum (IDLE, ISSUE, WAIT, PRESENT).
  - IDX_W constant.
  - J/K/DATA_W constants, replacing the bare macros.
- Optional sub-module `tile_walker`: holds the start_row/start_col/blk_idx counters with inputs init/advance, outputs last. The FSM instantiates it.

Test Plan:
- J=K=2, BUF_DEPTH=16, start with 4×4, blk_ready=1 → (row,col) = (0,0),(0,2),(2,0),(2,2). blk_idx 0..3. blk_last only on idx 3. done exactly 1 cycle after the 4th handshake. blk_valid period = 3 cycles.
- Same 4×4 config, blk_ready low for 5 cycles on tile 1 → blk_valid held high, (0,2) stable for all 5 cycles, no advance until ready.
- Configuration rejects (expect err=1 for one cycle, busy stays 0, coordinates unchanged):
  - 3×4 (rows not a multiple of J).
  - 0×4.
  - 4×8 (32 > 16).
- abort asserted in WAIT during tile 2, then a fresh start with 2×2 → returns to IDLE with no done. New scan gives a single block (0,0) with blk_last=1, then done.
- start pulsed during PRESENT with mat_rows/mat_cols changed → ignored. The original scan completes with the originally latched dimensions.
- rst asserted mid-scan in PRESENT together with blk_ready → all outputs 0 the next cycle, IDLE, no done pulse.
